// File: rtl/sevseg_pkg.sv
// ============================================================================
// Module      : sevseg_pkg
// Description : Shared constants for active-low 7-segment display blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sevseg_pkg;

  // Segment bit order within a 7-bit cathode vector: bit 0 = a ... bit 6 = g.
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_HA  = 7'h08;
  localparam logic [6:0] SEG_HB  = 7'h03;
  localparam logic [6:0] SEG_HC  = 7'h46;
  localparam logic [6:0] SEG_HD  = 7'h21;
  localparam logic [6:0] SEG_HE  = 7'h06;
  localparam logic [6:0] SEG_HF  = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/sevseg_scan_if.sv
// ============================================================================
// Module      : sevseg_scan_if
// Description : Display data in / anode-cathode pins out for sevseg_scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sevseg_scan_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                      en;
  logic [4*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]     dp;
  logic [NUM_DIGITS-1:0]     blank;
  logic [NUM_DIGITS-1:0]     an_o;
  logic [6:0]                seg_o;
  logic                      dp_o;

  modport master (
    output en, digits, dp, blank,
    input  an_o, seg_o, dp_o
  );

  modport slave (
    input  en, digits, dp, blank,
    output an_o, seg_o, dp_o
  );

endinterface

`default_nettype wire

// File: rtl/sevseg_decode.sv
// ============================================================================
// Module      : sevseg_decode
// Description : Combinational hex nibble to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_HA;
      4'hB: seg = SEG_HB;
      4'hC: seg = SEG_HC;
      4'hD: seg = SEG_HD;
      4'hE: seg = SEG_HE;
      4'hF: seg = SEG_HF;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sevseg_scan.sv
// ============================================================================
// Module      : sevseg_scan
// Description : N-digit time-multiplexed common-anode 7-segment scanner with
//               per-digit dp/blank and anti-ghosting dead time.
//               Optional macro SEVSEG_LZ_BLANK_EN: leading-zero suppression.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sevseg_scan
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int DEAD       = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sevseg_scan_if.slave  bus
);

  localparam int                    CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int                    IW       = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0]         CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = '1;

  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_n;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_n;
  logic                  tick;
  logic                  in_dead;
  logic [3:0]            nibble;
  logic [6:0]            seg_dec;
  logic                  dark;
  logic [NUM_DIGITS-1:0] lz_blank;

  assign tick = (cnt == CNT_LAST);

  // Outputs are registered from the next-state view so they line up with cnt/idx.
  always_comb begin
    cnt_n = '0;
    idx_n = '0;
    if (bus.en) begin
      cnt_n = tick ? '0 : cnt + CW'(1);
      idx_n = idx;
      if (tick) begin
        idx_n = (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
    end
  end

  generate
    if (DEAD > 0) begin : g_dead
      assign in_dead = (cnt_n < CW'(DEAD));
    end else begin : g_no_dead
      assign in_dead = 1'b0;
    end
  endgenerate

  assign nibble = bus.digits[{idx_n, 2'b00} +: 4];

  sevseg_decode u_decode (
    .nibble (nibble),
    .seg    (seg_dec)
  );

`ifdef SEVSEG_LZ_BLANK_EN
  // Suppression runs from the top digit down and stops at the first nonzero or dp.
  logic lz_run;
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run && (bus.digits[4*k +: 4] == 4'h0) && !bus.dp[k];
      lz_blank[k] = lz_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign dark = bus.blank[idx_n] | lz_blank[idx_n];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      bus.an_o  <= AN_OFF;
      bus.seg_o <= SEG_OFF;
      bus.dp_o  <= 1'b1;
    end else begin
      cnt <= cnt_n;
      idx <= idx_n;
      if (!bus.en) begin
        bus.an_o  <= AN_OFF;
        bus.seg_o <= SEG_OFF;
        bus.dp_o  <= 1'b1;
      end else begin
        bus.an_o  <= in_dead ? AN_OFF : ~(NUM_DIGITS'(1) << idx_n);
        bus.seg_o <= dark ? SEG_OFF : seg_dec;
        bus.dp_o  <= dark | ~bus.dp[idx_n];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sevseg_scan.sv
// ============================================================================
// Module      : tb_sevseg_scan
// Description : Directed self-checking bench for sevseg_scan (4 digits, DIV=4,
//               DEAD=1). Honours SEVSEG_LZ_BLANK_EN for leading-zero cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sevseg_scan;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

`ifdef SEVSEG_LZ_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'h40;
`endif

  sevseg_scan_if #(.NUM_DIGITS(4)) bus ();

  sevseg_scan #(
    .NUM_DIGITS (4),
    .DIV        (4),
    .DEAD       (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_off(input string tag);
    check({tag, " an"},  32'(bus.an_o),  32'h0F);
    check({tag, " seg"}, 32'(bus.seg_o), 32'h7F);
    check({tag, " dp"},  32'(bus.dp_o),  32'h1);
  endtask

  // One digit slot: a dead cycle (anodes off) then three lit cycles.
  task automatic run_slot(input string tag, input logic [3:0] an,
                          input logic [6:0] seg, input logic dpo);
    check({tag, " dead an"}, 32'(bus.an_o), 32'h0F);
    step();
    for (int c = 1; c < 4; c++) begin
      check($sformatf("%s c%0d an", tag, c),  32'(bus.an_o),  32'(an));
      check($sformatf("%s c%0d seg", tag, c), 32'(bus.seg_o), 32'(seg));
      check($sformatf("%s c%0d dp", tag, c),  32'(bus.dp_o),  32'(dpo));
      step();
    end
  endtask

  task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] dpo);
    run_slot({tag, " d0"}, 4'hE, s0, dpo[0]);
    run_slot({tag, " d1"}, 4'hD, s1, dpo[1]);
    run_slot({tag, " d2"}, 4'hB, s2, dpo[2]);
    run_slot({tag, " d3"}, 4'h7, s3, dpo[3]);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    bus.en     = 1'b1;
    bus.digits = 16'h1234;
    bus.dp     = 4'b0000;
    bus.blank  = 4'b0000;

    for (int i = 0; i < 3; i++) begin
      step();
      check_off($sformatf("reset%0d", i));
    end
    rst_n = 1'b1;

    run_frame("scan f0", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111);
    run_frame("scan f1", 7'h19, 7'h30, 7'h24, 7'h79, 4'b1111);

    bus.dp    = 4'b0010;
    bus.blank = 4'b0100;
    run_frame("dpblank", 7'h19, 7'h30, 7'h7F, 7'h79, 4'b1101);

    // Drop enable partway through the digit-2 slot.
    run_slot("endrop d0", 4'hE, 7'h19, 1'b1);
    run_slot("endrop d1", 4'hD, 7'h30, 1'b0);
    check("endrop d2 dead an", 32'(bus.an_o), 32'h0F);
    step();
    check("endrop d2 c1 an", 32'(bus.an_o), 32'h0B);
    step();
    check("endrop d2 c2 an", 32'(bus.an_o), 32'h0B);
    bus.en = 1'b0;
    step();
    check_off("en low c0");
    step();
    check_off("en low c1");
    bus.en = 1'b1;
    run_frame("en back", 7'h19, 7'h30, 7'h7F, 7'h79, 4'b1101);

    bus.dp     = 4'b0000;
    bus.blank  = 4'b0000;
    bus.digits = 16'hBA96;
    run_frame("hex BA96", 7'h02, 7'h10, 7'h08, 7'h03, 4'b1111);
    bus.digits = 16'hFEDC;
    run_frame("hex FEDC", 7'h46, 7'h21, 7'h06, 7'h0E, 4'b1111);
    bus.digits = 16'h8787;
    run_frame("hex 8787", 7'h78, 7'h00, 7'h78, 7'h00, 4'b1111);

    bus.digits = 16'h0050;
    run_frame("lz 0050", 7'h40, 7'h12, LZ_SEG, LZ_SEG, 4'b1111);
    bus.digits = 16'h0000;
    bus.dp     = 4'b0100;
    run_frame("lz dp2", 7'h40, 7'h40, 7'h40, LZ_SEG, 4'b1011);

    // Reset asserted during the digit-3 slot.
    bus.digits = 16'h1234;
    bus.dp     = 4'b0000;
    run_slot("rstmid d0", 4'hE, 7'h19, 1'b1);
    run_slot("rstmid d1", 4'hD, 7'h30, 1'b1);
    run_slot("rstmid d2", 4'hB, 7'h24, 1'b1);
    check("rstmid d3 dead an", 32'(bus.an_o), 32'h0F);
    step();
    check("rstmid d3 c1 an", 32'(bus.an_o), 32'h07);
    rst_n = 1'b0;
    step();
    check_off("rstmid off");
    rst_n = 1'b1;
    run_slot("resume d0", 4'hE, 7'h19, 1'b1);
    run_slot("resume d1", 4'hD, 7'h30, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sevseg_scan.md
# sevseg_scan

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It scans one digit per refresh slot, decodes a 4-bit hex nibble per digit, and adds per-digit decimal point, per-digit blanking, and anti-ghosting dead time. It replaces the fixed 4-digit scanner and sits between the display-data logic and the board's anode/cathode pins.

## Interface
- NUM_DIGITS, 4: digits scanned (≥2).
- DIV, 50000: clock cycles per digit slot (≥2).
- DEAD, 2: cycles at the start of each slot with all anodes off (0 ≤ DEAD < DIV).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  display enable, active high.
- digits  in  4*NUM_DIGITS  hex value per digit; digit k = digits[4k+3:4k]; digit 0 is rightmost.
- dp  in  NUM_DIGITS  decimal-point request per digit, active high.
- blank  in  NUM_DIGITS  force digit dark, active high.
- an_o  out  NUM_DIGITS  anode enables, active low, registered.
- seg_o  out  7  cathodes, active low, registered; seg_o[0]=a … seg_o[6]=g.
- dp_o  out  1  decimal-point cathode, active low, registered.

## Operation
- State: prescaler cnt (0..DIV-1) and digit index idx (0..NUM_DIGITS-1).
- tick = (cnt == DIV-1). cnt increments each cycle and wraps to 0 on tick. On tick, idx increments and wraps from NUM_DIGITS-1 to 0.
- idx_n = next value of idx. cnt_n = next value of cnt.
- Registered outputs each cycle, computed from idx_n/cnt_n:
  - an_o: bit idx_n low, others high. All high if cnt_n < DEAD.
  - seg_o: ~decode(digit idx_n).
  - dp_o: ~dp[idx_n].
- Blanked digit: seg_o = 7'h7F and dp_o = 1. The anode still follows the scan.
- Decoder covers full hex 0–F using the standard a–g patterns. Examples as active-low seg_o: 0→7'h40, 1→7'h79, 4→7'h19, 5→7'h12, 8→7'h00, F→7'h0E.
- en low: cnt and idx are cleared to 0; an_o = all ones; seg_o = 7'h7F; dp_o = 1.
- en rising: scanning starts at digit 0 with cnt = 0, exactly as after reset.
- Input changes (digits, dp, blank) are reflected on outputs the next cycle; no slot-boundary sampling.

## Timing
- Reset (rst_n low at an edge): cnt = 0, idx = 0, an_o = all ones, seg_o = 7'h7F, dp_o = 1.
- Reset has priority over en. Reset mid-scan aborts the slot immediately.
- Latency: one cycle from input to output.
- Slot length: exactly DIV cycles. Anodes are dark for the first DEAD cycles of each slot (DEAD = 0 means no dead time).
- Full frame: NUM_DIGITS*DIV cycles. Refresh is uniform across the wrap.
- Simultaneous tick and en falling: en wins; state is cleared.

## Configuration
- SEVSEG_LZ_BLANK_EN defined: leading-zero suppression. Digit k (k ≥ 1) is blanked when its nibble is 0, every higher digit's nibble is 0, and its dp is 0. Digit 0 is never suppressed. A dp on a digit stops suppression for that digit and all lower digits.
- SEVSEG_LZ_BLANK_EN undefined: zeros display normally. Only the blank input darkens digits.

## Structure
- Shared package sevseg_pkg holds:
  - 7-bit active-low segment constants for 0–F;
  - SEG_OFF = 7'h7F;
  - the segment bit-order definition.
- Sub-module sevseg_decode: combinational 4-bit nibble → 7-bit active-low segments. Shared with other display blocks.
- Counter widths: $clog2(DIV) for cnt and $clog2(NUM_DIGITS) for idx. Both compare-and-wrap; no power-of-two assumption.

## Test plan
Bench parameters: NUM_DIGITS=4, DIV=4, DEAD=1.
- Reset: rst_n low 3 cycles with en=1 → an_o=4'hF, seg_o=7'h7F, dp_o=1 throughout.
- Scan: digits=16'h1234, en=1, dp=0, blank=0.
  - Each 4-cycle slot: one cycle an_o=4'hF, then 3 cycles on the digit.
  - Digit sequence per frame: 4'hE with seg_o=7'h19, 4'hD with 7'h30, 4'hB with 7'h24, 4'h7 with 7'h79.
  - Frame repeats with no gap at the wrap.
- Decimal point and blank: dp=4'b0010, blank=4'b0100 → dp_o=0 only in digit-1 slots; seg_o=7'h7F and dp_o=1 in digit-2 slots.
- en dropped mid-slot of digit 2 → next cycle all outputs are off. en restored → first lit anode is 4'hE after 1 dead cycle.
- Leading zeros: digits=16'h0050.
  - With macro: digits 3 and 2 show seg_o=7'h7F; digit 1 shows 7'h12; digit 0 shows 7'h40.
  - Without macro: digits 3 and 2 show 7'h40.
- Reset asserted mid-frame during digit 3 → outputs off the next cycle. After release, scanning resumes at digit 0.
